// File: rtl/mmio_timer.sv
// Memory-mapped prescaled down-counter on the CPU data bus: one-shot or
// auto-reload, sticky expiry flag, registered level interrupt.
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0020,
   parameter int          PRESC_W   = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        memwrite,
   input  logic [31:0] memaddr,
   input  logic [31:0] memwritedata,
   output logic        hit,
   output logic [31:0] readdata,
   output logic        irq
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_LOAD   = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   logic [1:0]         r_state;
   logic               r_en;
   logic               r_auto;
   logic               r_irq_en;
   logic [PRESC_W-1:0] r_presc;
   logic [PRESC_W-1:0] r_presc_cnt;
   logic [31:0]        r_load;
   logic [31:0]        r_count;
   logic               r_expired;
   logic               r_irq;

   logic [1:0]  w_off;
   logic        w_wr;
   logic        w_wr_ctrl;
   logic        w_wr_load;
   logic        w_wr_count;
   logic        w_wr_stat;
   logic        w_wrap;
   logic        w_tick;
   logic        w_expire;
   logic        w_unused;

   assign hit        = (memaddr[31:4] == BASE_ADDR[31:4]);
   assign w_off      = memaddr[3:2];
   assign w_wr       = hit & memwrite;
   assign w_wr_ctrl  = w_wr && (w_off == A_CTRL);
   assign w_wr_load  = w_wr && (w_off == A_LOAD);
   assign w_wr_count = w_wr && (w_off == A_COUNT);
   assign w_wr_stat  = w_wr && (w_off == A_STATUS);
   assign w_unused   = ^memaddr[1:0];

   // A COUNT or CTRL write on the tick edge swallows the tick; the prescaler
   // still wraps on its own schedule unless the CTRL write restarts it.
   assign w_wrap   = (r_state == S_RUN) && (r_presc_cnt == r_presc);
   assign w_tick   = w_wrap && !w_wr_count && !w_wr_ctrl;
   assign w_expire = w_tick && (r_count == 32'd0);

   always_comb begin
      readdata = 32'd0;
      if (hit) begin
         case (w_off)
            A_CTRL: begin
               readdata[0]                = r_en;
               readdata[1]                = r_auto;
               readdata[2]                = r_irq_en;
               readdata[16 +: PRESC_W]    = r_presc;
            end
            A_LOAD:   readdata = r_load;
            A_COUNT:  readdata = r_count;
            default:  readdata = {31'd0, r_expired};
         endcase
      end
   end

   assign irq = r_irq;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_en        <= 1'b0;
         r_auto      <= 1'b0;
         r_irq_en    <= 1'b0;
         r_presc     <= '0;
         r_presc_cnt <= '0;
         r_load      <= 32'd0;
         r_count     <= 32'd0;
         r_expired   <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         r_irq <= r_expired & r_irq_en;

         case (r_state)
            S_RUN: begin
               r_presc_cnt <= w_wrap ? '0 : r_presc_cnt + PRESC_W'(1);
               if (w_tick) begin
                  if (r_count != 32'd0) begin
                     r_count <= r_count - 32'd1;
                  end else if (r_auto) begin
                     r_count <= r_load;
                  end else begin
                     r_en    <= 1'b0;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         // Set beats clear when both land on the same edge.
         if (w_wr_stat && memwritedata[0]) r_expired <= 1'b0;
         if (w_expire)                     r_expired <= 1'b1;

         if (w_wr_load)  r_load  <= memwritedata;
         if (w_wr_count) r_count <= memwritedata;

         if (w_wr_ctrl) begin
            r_en     <= memwritedata[0];
            r_auto   <= memwritedata[1];
            r_irq_en <= memwritedata[2];
            r_presc  <= memwritedata[16 +: PRESC_W];
            if (memwritedata[0]) begin
               r_state     <= S_RUN;
               r_presc_cnt <= '0;
            end else begin
               r_state <= S_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: bus stores/loads driven mid-cycle, results
// compared against hand-computed cycle-exact values.
module tb_mmio_timer;

   localparam logic [31:0] BASE = 32'hFFFF_0020;
   localparam logic [31:0] A_CTRL = BASE + 32'h0;
   localparam logic [31:0] A_LOAD = BASE + 32'h4;
   localparam logic [31:0] A_CNT  = BASE + 32'h8;
   localparam logic [31:0] A_STAT = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] memaddr = 32'd0;
   logic [31:0] memwritedata = 32'd0;
   logic        hit;
   logic [31:0] readdata;
   logic        irq;

   int n_chk = 0;
   int n_err = 0;

   mmio_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .memwrite     (memwrite),
      .memaddr      (memaddr),
      .memwritedata (memwritedata),
      .hit          (hit),
      .readdata     (readdata),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Store lands on the next rising edge; returns 1 time unit after it.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      memaddr = a; memwritedata = d; memwrite = 1'b1;
      @(posedge clk);
      #1 memwrite = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      memwrite = 1'b0; memaddr = a;
      #1 d = readdata;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      chk(tag, d, exp);
   endtask

   initial begin
      logic [31:0] d;
      int n;

      // reset values and mid-run reset
      cyc(2);
      @(negedge clk) reset_n = 1'b1;
      cyc(1);
      chk_rd("rst_ctrl", A_CTRL, 32'h0);
      chk_rd("rst_load", A_LOAD, 32'h0);
      chk_rd("rst_cnt",  A_CNT,  32'h0);
      chk_rd("rst_stat", A_STAT, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'h0);
      wr(A_LOAD, 32'd2);
      wr(A_CNT, 32'd2);
      wr(A_CTRL, 32'h0000_0007);
      cyc(1);
      #1 reset_n = 1'b0;
      chk_rd("mid_ctrl", A_CTRL, 32'h0);
      chk_rd("mid_load", A_LOAD, 32'h0);
      chk_rd("mid_cnt",  A_CNT,  32'h0);
      chk_rd("mid_stat", A_STAT, 32'h0);
      chk("mid_irq", {31'd0, irq}, 32'h0);
      @(negedge clk) reset_n = 1'b1;
      cyc(10);
      chk_rd("post_stat", A_STAT, 32'h0);
      chk("post_irq", {31'd0, irq}, 32'h0);

      // one-shot, PRESC=0: expiry 4 clocks after CTRL write
      wr(A_LOAD, 32'd3);
      wr(A_CNT, 32'd3);
      wr(A_CTRL, 32'h0000_0005);
      cyc(3);
      chk_rd("os_stat_e3", A_STAT, 32'h0);
      cyc(1);
      chk_rd("os_stat_e4", A_STAT, 32'h1);
      chk("os_irq_e4", {31'd0, irq}, 32'h0);
      chk_rd("os_cnt", A_CNT, 32'h0);
      chk_rd("os_ctrl", A_CTRL, 32'h4);
      cyc(1);
      chk("os_irq_e5", {31'd0, irq}, 32'h1);
      wr(A_STAT, 32'h1);
      chk_rd("os_clr", A_STAT, 32'h0);
      chk("os_irq_hold", {31'd0, irq}, 32'h1);
      cyc(1);
      chk("os_irq_off", {31'd0, irq}, 32'h0);

      // auto-reload, PRESC=1, LOAD=2: period 6
      wr(A_CNT, 32'd2);
      wr(A_LOAD, 32'd2);
      wr(A_CTRL, 32'h0001_0003);                 // E0
      cyc(1); chk_rd("ar_cnt_e1", A_CNT, 32'd2);
      cyc(1); chk_rd("ar_cnt_e2", A_CNT, 32'd1);
      cyc(2); chk_rd("ar_cnt_e4", A_CNT, 32'd0);
      cyc(1); chk_rd("ar_stat_e5", A_STAT, 32'h0);
      cyc(1); chk_rd("ar_stat_e6", A_STAT, 32'h1);
      chk_rd("ar_cnt_e6", A_CNT, 32'd2);
      chk("ar_irq", {31'd0, irq}, 32'h0);
      wr(A_STAT, 32'h0);                          // E7
      chk_rd("ar_w0", A_STAT, 32'h1);
      wr(A_STAT, 32'h1);                          // E8
      chk_rd("ar_clr", A_STAT, 32'h0);
      cyc(3); chk_rd("ar_stat_e11", A_STAT, 32'h0);
      cyc(1); chk_rd("ar_stat_e12", A_STAT, 32'h1);

      // collisions
      wr(A_STAT, 32'h1);                          // E13
      chk_rd("co_clr", A_STAT, 32'h0);
      cyc(4);
      wr(A_STAT, 32'h1);                          // E18: expiry edge
      chk_rd("co_setwins", A_STAT, 32'h1);
      chk_rd("co_reload", A_CNT, 32'd2);
      cyc(1);
      wr(A_CNT, 32'd9);                           // E20: tick edge
      chk_rd("co_cntwr", A_CNT, 32'd9);
      cyc(1); chk_rd("co_cnt_e21", A_CNT, 32'd9);
      cyc(1); chk_rd("co_cnt_e22", A_CNT, 32'd8);
      cyc(17);
      wr(A_LOAD, 32'd5);                          // E40: reload edge
      chk_rd("co_oldload", A_CNT, 32'd2);
      chk_rd("co_newload", A_LOAD, 32'd5);
      cyc(6);                                     // E46
      chk_rd("co_nextper", A_CNT, 32'd5);
      wr(A_CTRL, 32'h0);
      cyc(4);
      chk_rd("stop_cnt", A_CNT, 32'd5);
      chk_rd("stop_ctrl", A_CTRL, 32'h0);

      // decode
      memaddr = BASE + 32'h10;
      #1 chk("dec_hit_hi", {31'd0, hit}, 32'h0);
      chk("dec_rd_hi", readdata, 32'h0);
      memaddr = BASE - 32'h4;
      #1 chk("dec_hit_lo", {31'd0, hit}, 32'h0);
      chk("dec_rd_lo", readdata, 32'h0);
      memaddr = A_STAT;
      #1 chk("dec_hit_in", {31'd0, hit}, 32'h1);
      wr(BASE + 32'h10, 32'hFFFF_FFFF);
      wr(BASE + 32'h18, 32'hFFFF_FFFF);
      wr(BASE - 32'h4, 32'hFFFF_FFFF);
      wr(BASE - 32'h10, 32'hFFFF_FFFF);
      chk_rd("dec_ctrl", A_CTRL, 32'h0);
      chk_rd("dec_load", A_LOAD, 32'd5);
      chk_rd("dec_cnt",  A_CNT,  32'd5);
      chk_rd("dec_stat", A_STAT, 32'h1);

      // CPU-style store/poll/load sequence
      wr(A_STAT, 32'h1);
      wr(A_LOAD, 32'd4);
      wr(A_CNT, 32'd1);
      wr(A_CTRL, 32'h0002_0003);
      n = 0;
      rd(A_STAT, d);
      while (d[0] !== 1'b1 && n < 100) begin
         cyc(1);
         n++;
         rd(A_STAT, d);
      end
      chk("cpu_poll", d, 32'h1);
      chk("cpu_lat", n, 32'd6);
      chk_rd("cpu_cnt", A_CNT, 32'd4);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
